// File: rtl/line_fill_mem_pkg.sv
// Shared types and default configuration for the line_fill_mem refill responder.
package line_fill_mem_pkg;

  localparam int unsigned DefLw  = 512;
  localparam int unsigned DefWw  = 32;
  localparam int unsigned DefAw  = 32;
  localparam int unsigned DefLat = 4;

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StRead,
    StDrain,
    StDone
  } state_e;

endpackage

// File: rtl/line_fill_mem_assembler.sv
// Line holding register: decodes the returning word's slot into a one-hot write enable
// and merges that word into the LW-bit line; all other slots keep their contents.
module line_fill_mem_assembler #(
  parameter int unsigned LW   = 512,
  parameter int unsigned WW   = 32,
  parameter int unsigned IdxW = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [IdxW-1:0] wr_slot,
  input  logic [WW-1:0]   wr_data,
  output logic [LW-1:0]   line
);

  localparam int unsigned NW = LW / WW;

  logic [NW-1:0] slot_we;
  logic [LW-1:0] line_q;

  always_comb begin
    slot_we = '0;
    if (wr_en) begin
      slot_we[wr_slot] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      line_q <= '0;
    end else begin
      for (int i = 0; i < NW; i++) begin
        if (slot_we[i]) begin
          line_q[i*WW +: WW] <= wr_data;
        end
      end
    end
  end

  assign line = line_q;

endmodule

// File: rtl/line_fill_mem.sv
// Memory-side line refill responder: reads LW/WW words from a 1-cycle sync SRAM and returns one line.
// Define CRIT_WORD_FIRST_EN to start the read sequence at the requested word (wrapping in the line).
module line_fill_mem
  import line_fill_mem_pkg::*;
#(
  parameter int unsigned LW  = DefLw,
  parameter int unsigned WW  = DefWw,
  parameter int unsigned AW  = DefAw,
  parameter int unsigned LAT = DefLat
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m_start,
  input  logic [AW-1:0] m_addr,
  output logic [LW-1:0] m_data,
  output logic          m_done,
  output logic          busy,
  output logic          mem_en,
  output logic [AW-1:0] mem_addr,
  input  logic [WW-1:0] mem_rdata
);

  localparam int unsigned NW       = LW / WW;
  localparam int unsigned IdxW     = (NW > 1) ? $clog2(NW) : 1;
  localparam int unsigned OffBits  = $clog2(LW / 8);
  localparam int unsigned WoffBits = $clog2(WW / 8);
  localparam int unsigned LatW     = (LAT > 0) ? $clog2(LAT + 1) : 1;
  localparam logic [LatW-1:0] LatInit = (LAT == 0) ? '0 : LatW'(LAT - 1);

  state_e          state_q, state_d;
  logic [LatW-1:0] lat_cnt_q, lat_cnt_d;
  logic [IdxW-1:0] rd_cnt_q, rd_cnt_d;
  logic [IdxW-1:0] start_word_q, start_word_d;
  logic [AW-1:0]   base_q, base_d;
  logic            mem_en_q, mem_en_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [IdxW-1:0] mem_slot_q, mem_slot_d;
  logic            rd_vld_q;
  logic [IdxW-1:0] rd_slot_q;
  logic [IdxW-1:0] word_idx;
  logic [IdxW-1:0] req_word;
  logic            unused_addr_bits;

`ifdef CRIT_WORD_FIRST_EN
  assign req_word = m_addr[WoffBits +: IdxW];
`else
  assign req_word = '0;
`endif

  // Offset bits below the line are dropped (or only partly used for the start word).
  assign unused_addr_bits = ^m_addr[OffBits-1:0];

  // Truncation to IdxW bits keeps the sequence inside the line.
  assign word_idx = start_word_q + rd_cnt_q;

  always_comb begin
    state_d      = state_q;
    lat_cnt_d    = lat_cnt_q;
    rd_cnt_d     = rd_cnt_q;
    start_word_d = start_word_q;
    base_d       = base_q;
    mem_en_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_slot_d   = mem_slot_q;
    unique case (state_q)
      StIdle: begin
        if (m_start) begin
          base_d       = m_addr & ~AW'(LW / 8 - 1);
          start_word_d = req_word;
          rd_cnt_d     = '0;
          lat_cnt_d    = LatInit;
          state_d      = (LAT == 0) ? StRead : StWait;
        end
      end
      StWait: begin
        if (lat_cnt_q == '0) begin
          state_d = StRead;
        end else begin
          lat_cnt_d = lat_cnt_q - LatW'(1);
        end
      end
      StRead: begin
        mem_en_d   = 1'b1;
        mem_addr_d = base_q | (AW'(word_idx) << WoffBits);
        mem_slot_d = word_idx;
        rd_cnt_d   = rd_cnt_q + IdxW'(1);
        if (rd_cnt_q == IdxW'(NW - 1)) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        // The SRAM port is registered, so the last word lands two cycles after READ ends.
        if (!mem_en_q) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      lat_cnt_q    <= '0;
      rd_cnt_q     <= '0;
      start_word_q <= '0;
      base_q       <= '0;
      mem_en_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_slot_q   <= '0;
      rd_vld_q     <= 1'b0;
      rd_slot_q    <= '0;
    end else begin
      state_q      <= state_d;
      lat_cnt_q    <= lat_cnt_d;
      rd_cnt_q     <= rd_cnt_d;
      start_word_q <= start_word_d;
      base_q       <= base_d;
      mem_en_q     <= mem_en_d;
      mem_addr_q   <= mem_addr_d;
      mem_slot_q   <= mem_slot_d;
      rd_vld_q     <= mem_en_q;
      rd_slot_q    <= mem_slot_q;
    end
  end

  line_fill_mem_assembler #(
    .LW   (LW),
    .WW   (WW),
    .IdxW (IdxW)
  ) u_assembler (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (rd_vld_q),
    .wr_slot (rd_slot_q),
    .wr_data (mem_rdata),
    .line    (m_data)
  );

  assign m_done   = (state_q == StDone);
  assign busy     = (state_q != StIdle);
  assign mem_en   = mem_en_q;
  assign mem_addr = mem_addr_q;

endmodule

// File: tb/tb_line_fill_mem.sv
// Bench for line_fill_mem: default-latency DUT plus a LAT=0 DUT, each with a 1-cycle SRAM model.
module tb_line_fill_mem;

  localparam int unsigned LW  = 512;
  localparam int unsigned WW  = 32;
  localparam int unsigned AW  = 32;
  localparam int unsigned LAT = 4;
  localparam int unsigned NW  = LW / WW;
`ifdef CRIT_WORD_FIRST_EN
  localparam bit Crit = 1'b1;
`else
  localparam bit Crit = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          m_start, m_start0;
  logic [AW-1:0] m_addr, m_addr0;
  logic [LW-1:0] m_data, m_data0;
  logic          m_done, m_done0;
  logic          busy, busy0;
  logic          mem_en, mem_en0;
  logic [AW-1:0] mem_addr, mem_addr0;
  logic [WW-1:0] mem_rdata, mem_rdata0;

  int            n_cmp = 0;
  int            n_err = 0;
  logic [31:0]   seq[$];
  logic [LW-1:0] prev_exp;

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_en)  mem_rdata  <= mem_addr  ^ 32'hA5A5_0000;
  always @(posedge clk) if (mem_en0) mem_rdata0 <= mem_addr0 ^ 32'hA5A5_0000;

  line_fill_mem #(.LW(LW), .WW(WW), .AW(AW), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .m_start(m_start), .m_addr(m_addr), .m_data(m_data),
    .m_done(m_done), .busy(busy), .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
  );

  line_fill_mem #(.LW(LW), .WW(WW), .AW(AW), .LAT(0)) dut0 (
    .clk(clk), .rst(rst), .m_start(m_start0), .m_addr(m_addr0), .m_data(m_data0),
    .m_done(m_done0), .busy(busy0), .mem_en(mem_en0), .mem_addr(mem_addr0),
    .mem_rdata(mem_rdata0)
  );

  task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected line: word i is the SRAM content at line base + 4*i.
  function automatic logic [LW-1:0] model_line(input logic [31:0] addr);
    logic [31:0]   base;
    logic [LW-1:0] l;
    base = addr & 32'hFFFF_FFC0;
    for (int i = 0; i < NW; i++) l[i*WW +: WW] = (base + 32'(4 * i)) ^ 32'hA5A5_0000;
    return l;
  endfunction

  function automatic logic [31:0] model_rd_addr(input logic [31:0] addr, input int i);
    int start;
    start = Crit ? int'((addr >> 2) % NW) : 0;
    return (addr & 32'hFFFF_FFC0) + 32'(4 * ((start + i) % NW));
  endfunction

  // Issues one request on the main DUT; caller is one #1 past an edge with the DUT idle.
  task automatic run_fill(input logic [31:0] addr, output int lat, output logic [LW-1:0] early,
                          output logic busy1);
    m_addr  = addr;
    m_start = 1'b1;
    @(posedge clk); #1;
    m_start = 1'b0;
    seq.delete();
    lat   = -1;
    early = 'x;
    busy1 = busy;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (mem_en) seq.push_back(mem_addr);
      if (k == LAT + 2) early = m_data;
      if (m_done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic fill_and_check(input string tag, input logic [31:0] addr);
    int            lat;
    int            bad;
    logic [LW-1:0] early;
    logic          busy1;
    run_fill(addr, lat, early, busy1);
    check({tag, "_latency"}, LW'(lat), LW'(LAT + NW + 2));
    check({tag, "_busy_start"}, LW'(busy1), LW'(1));
    check({tag, "_old_words_kept"}, early, prev_exp);
    check({tag, "_line"}, m_data, model_line(addr));
    check({tag, "_reads"}, LW'(seq.size()), LW'(NW));
    check({tag, "_first_addr"}, LW'(seq.size() > 0 ? seq[0] : 32'hx), LW'(model_rd_addr(addr, 0)));
    check({tag, "_addr14"}, LW'(seq.size() > 14 ? seq[14] : 32'hx), LW'(model_rd_addr(addr, 14)));
    bad = 0;
    for (int i = 0; i < seq.size(); i++) if (seq[i] !== model_rd_addr(addr, i)) bad++;
    check({tag, "_order_errs"}, LW'(bad), LW'(0));
    @(posedge clk); #1;
    check({tag, "_busy_after"}, LW'(busy), LW'(0));
    check({tag, "_done_pulse"}, LW'(m_done), LW'(0));
    prev_exp = model_line(addr);
  endtask

  initial begin
    logic [31:0] a;
    int          dones;
    int          done_k;
    int          dk[3];
    int          nd;

    rst = 1'b1; m_start = 1'b0; m_addr = '0; m_start0 = 1'b0; m_addr0 = '0;
    prev_exp = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_done", LW'(m_done), LW'(0));
    check("rst_busy", LW'(busy), LW'(0));
    check("rst_mem_en", LW'(mem_en), LW'(0));
    check("rst_mem_addr", LW'(mem_addr), LW'(0));
    check("rst_data", m_data, LW'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    fill_and_check("addr0", 32'h0);
    fill_and_check("crit", 32'hABCD_EF88);

    // Extra strobes mid-fill and in the DONE cycle must both be dropped.
    a = $urandom;
    m_addr = a; m_start = 1'b1;
    @(posedge clk); #1;
    m_start = 1'b0; dones = 0; done_k = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (m_done) begin
        dones++;
        if (done_k < 0) done_k = k;
      end
      if (k == 5 || k == 22) begin
        m_start = 1'b1;
        m_addr  = $urandom;
      end else begin
        m_start = 1'b0;
      end
    end
    check("ignore_done_count", LW'(dones), LW'(1));
    check("ignore_done_cycle", LW'(done_k), LW'(22));
    check("ignore_busy_end", LW'(busy), LW'(0));
    check("ignore_line", m_data, model_line(a));
    prev_exp = model_line(a);

    // Reset in the middle of a fill.
    a = $urandom;
    m_addr = a; m_start = 1'b1;
    @(posedge clk); #1;
    m_start = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_done", LW'(m_done), LW'(0));
    check("midrst_mem_en", LW'(mem_en), LW'(0));
    check("midrst_data", m_data, LW'(0));
    check("midrst_busy", LW'(busy), LW'(0));
    check("midrst_mem_addr", LW'(mem_addr), LW'(0));
    rst = 1'b0;
    dones = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (m_done || mem_en) dones++;
    end
    check("midrst_quiet", LW'(dones), LW'(0));
    prev_exp = '0;
    fill_and_check("after_rst", $urandom);

    // Back-to-back fills with the line held stable in between.
    fill_and_check("b2b0", 32'h000);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("b2b_hold", m_data, prev_exp);
    end
    fill_and_check("b2b1", 32'h040);

    for (int r = 0; r < 5; r++) fill_and_check("rand", $urandom);

    // LAT=0 instance with m_start held high across three fills.
    a = $urandom;
    m_addr0 = a; m_start0 = 1'b1;
    @(posedge clk); #1;
    nd = 0;
    dk[0] = -1; dk[1] = -1; dk[2] = -1;
    for (int k = 1; k <= 70 && nd < 3; k++) begin
      @(posedge clk); #1;
      if (m_done0) begin
        dk[nd] = k;
        nd++;
        check("lat0_line", m_data0, model_line(a));
        a = $urandom;
        m_addr0 = a;
        if (nd == 3) m_start0 = 1'b0;
      end
    end
    check("lat0_done_count", LW'(nd), LW'(3));
    check("lat0_first", LW'(dk[0]), LW'(NW + 2));
    check("lat0_period1", LW'(dk[1] - dk[0]), LW'(NW + 4));
    check("lat0_period2", LW'(dk[2] - dk[1]), LW'(NW + 4));
    repeat (2) @(posedge clk);
    #1;
    check("lat0_idle", LW'(busy0), LW'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
